// File: rtl/opti_sos_engine_if.sv
// Sample stream bundle for the biquad cascade engine.
// The source feeds input samples and the sink takes filtered samples, each with a valid/ready handshake.
// The master modport is the environment's view of the bundle; the slave modport is the engine's view.
interface opti_sos_engine_if #(
  parameter int DW = 24
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/opti_sos_engine.sv
// Time-multiplexed cascade of transposed direct-form-II biquad sections.
// One multiply/accumulate datapath is shared by all NSEC sections. Each section takes two cycles:
//   CALC_Y produces the rounded and saturated section output.
//   UPD updates that section's two state registers and forwards y to the next section.
// Coefficients come combinationally from an external ROM that is addressed by sos_idx.
module opti_sos_engine #(
  parameter int NSEC   = 4,
  parameter int SIDX_W = 2,
  parameter int DW     = 24,
  parameter int CW     = 24,
  parameter int CFRAC  = 22,
  parameter int ACC_W  = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  opti_sos_engine_if.slave         bus,
  output logic [SIDX_W-1:0]        sos_idx,
  input  logic signed [CW-1:0]     b0,
  input  logic signed [CW-1:0]     b1,
  input  logic signed [CW-1:0]     b2,
  input  logic signed [CW-1:0]     a1,
  input  logic signed [CW-1:0]     a2,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CALC_Y, UPD, OUT} state_t;

  localparam logic [SIDX_W-1:0] K_LAST = SIDX_W'(NSEC - 1);
  // Adding half an LSB of the output before the arithmetic shift rounds half-up.
  localparam logic signed [ACC_W-1:0] RND_C = {{(ACC_W-CFRAC){1'b0}}, 1'b1, {(CFRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   state_r, state_s;
  logic [SIDX_W-1:0]        k_r;
  logic signed [DW-1:0]     x_r, y_r;
  logic [DW-1:0]            out_data_r;
  logic signed [ACC_W-1:0]  s1_r [NSEC];
  logic signed [ACC_W-1:0]  s2_r [NSEC];

  logic signed [CW+DW-1:0]  pb0_s, pb1_s, pb2_s, pa1_s, pa2_s;
  logic signed [ACC_W-1:0]  acc_s, shifted_s, s1_new_s, s2_new_s;
  logic signed [DW-1:0]     y_sat_s;

  // Sign-extend a full-precision product into the state domain.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [CW+DW-1:0] p);
    return $signed({{(ACC_W-CW-DW){p[CW+DW-1]}}, p});
  endfunction

  // Clamp a shifted accumulator to the signed output sample range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    logic signed [DW-1:0] r;
    if (v > Y_MAX) begin
      r = {1'b0, {(DW-1){1'b1}}};
    end else if (v < Y_MIN) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  // The products use the current section's coefficients.
  // The states wrap silently; only y is rounded and clamped.
  assign pb0_s     = b0 * x_r;
  assign pb1_s     = b1 * x_r;
  assign pb2_s     = b2 * x_r;
  assign pa1_s     = a1 * y_r;
  assign pa2_s     = a2 * y_r;
  assign acc_s     = sext_prod(pb0_s) + s1_r[k_r];
  assign shifted_s = (acc_s + RND_C) >>> CFRAC;
  assign y_sat_s   = sat_dw(shifted_s);
  assign s1_new_s  = sext_prod(pb1_s) - sext_prod(pa1_s) + s2_r[k_r];
  assign s2_new_s  = sext_prod(pb2_s) - sext_prod(pa2_s);

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == OUT);
  assign bus.out_data  = out_data_r;
  assign busy          = (state_r != IDLE);
  assign sos_idx       = k_r;

  // State register: reset and clear both force IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (clear) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode for the per-section two-cycle walk.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = CALC_Y;
        end else begin
          state_s = IDLE;
        end
      end
      CALC_Y: state_s = UPD;
      UPD: begin
        if (k_r == K_LAST) begin
          state_s = OUT;
        end else begin
          state_s = CALC_Y;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath registers: section index, sample pipeline, section states and output hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_r        <= {SIDX_W{1'b0}};
      x_r        <= {DW{1'b0}};
      y_r        <= {DW{1'b0}};
      out_data_r <= {DW{1'b0}};
      for (int i = 0; i < NSEC; i++) begin
        s1_r[i] <= {ACC_W{1'b0}};
        s2_r[i] <= {ACC_W{1'b0}};
      end
    end else if (clear) begin
      k_r <= {SIDX_W{1'b0}};
      for (int i = 0; i < NSEC; i++) begin
        s1_r[i] <= {ACC_W{1'b0}};
        s2_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            x_r <= bus.in_data;
            k_r <= {SIDX_W{1'b0}};
          end
        end
        CALC_Y: y_r <= y_sat_s;
        UPD: begin
          s1_r[k_r] <= s1_new_s;
          s2_r[k_r] <= s2_new_s;
          x_r       <= y_r;
          if (k_r == K_LAST) begin
            out_data_r <= y_r;
          end else begin
            k_r <= k_r + {{(SIDX_W-1){1'b0}}, 1'b1};
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            k_r <= {SIDX_W{1'b0}};
          end
        end
        default: k_r <= {SIDX_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_opti_sos_engine.sv
// Scoreboard bench for opti_sos_engine.
// A stub coefficient table stands in for the ROM. Stimulus pushes the expected outputs into a queue,
// and a negedge monitor pops and compares whenever a filtered sample is handed over.
module tb_opti_sos_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, clear, busy;
  logic [1:0]        sos_idx;
  logic signed [23:0] b0, b1, b2, a1, a2;
  logic signed [23:0] tb0 [4], tb1 [4], tb2 [4], ta1 [4], ta2 [4];
  logic signed [49:0] ms1 [4], ms2 [4];
  logic [23:0]       exp_q [$];
  logic [23:0]       imp_ref [8];
  int                checks = 0;
  int                errors = 0;

  opti_sos_engine_if #(.DW(24)) bus ();

  opti_sos_engine dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus), .sos_idx(sos_idx),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .busy(busy)
  );

  // Stub ROM: combinational lookup by section index.
  always_comb begin
    b0 = tb0[sos_idx];
    b1 = tb1[sos_idx];
    b2 = tb2[sos_idx];
    a1 = ta1[sos_idx];
    a2 = ta2[sos_idx];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every handed-over output must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h required=none", bus.out_data);
      end else begin
        check("out_data", {8'h00, bus.out_data}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  // Golden cascade model: sample-level, one section after another.
  function automatic logic [23:0] model_step(input logic signed [23:0] xin);
    logic signed [23:0] xv, yv;
    logic signed [49:0] acc, r;
    xv = xin;
    for (int k = 0; k < 4; k++) begin
      acc = tb0[k] * xv + ms1[k];
      r = (acc + 50'sd2097152) >>> 22;
      if (r > 50'sd8388607) yv = 24'sh7FFFFF;
      else if (r < -50'sd8388608) yv = 24'sh800000;
      else yv = r[23:0];
      ms1[k] = tb1[k] * xv - ta1[k] * yv + ms2[k];
      ms2[k] = tb2[k] * xv - ta2[k] * yv;
      xv = yv;
    end
    return xv;
  endfunction

  task automatic zero_model();
    for (int k = 0; k < 4; k++) begin
      ms1[k] = 50'sd0;
      ms2[k] = 50'sd0;
    end
  endtask

  task automatic set_all(input logic [23:0] v0, input logic [23:0] v1, input logic [23:0] v2,
                         input logic [23:0] w1, input logic [23:0] w2);
    for (int k = 0; k < 4; k++) begin
      tb0[k] = v0; tb1[k] = v1; tb2[k] = v2; ta1[k] = w1; ta2[k] = w2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one sample, record its expectation, check the latency and let OUT complete.
  task automatic send(input logic [23:0] d, input logic [23:0] e);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin tick(); n++; end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    bus.in_data = d;
    bus.in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin tick(); n++; end
    check("latency", n, 32'd8);
    tick();
  endtask

  // Clear while a sample is offered in IDLE: states flushed, sample not taken.
  task automatic do_clear();
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 24'h7FFFFF;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_no_accept", {31'd0, bus.in_ready}, 32'd1);
    tick();
    zero_model();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 24'h000000; bus.out_ready = 1'b1;
    set_all(24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    zero_model();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sos_idx", {30'd0, sos_idx}, 32'd0);
    check("rst_out_data", {8'h00, bus.out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Unity gain in every section.
    set_all(24'h400000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    send(24'h100000, 24'h100000);

    // The first section is a one-pole recursion y = x + 0.5*y[n-1]; the other sections pass through.
    do_clear();
    ta1[0] = 24'hE00000;
    send(24'h200000, 24'h200000);
    send(24'h000000, 24'h100000);
    send(24'h000000, 24'h080000);
    send(24'h000000, 24'h040000);

    // Saturation at both ends of the range.
    do_clear();
    set_all(24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    send(24'h7FFFFF, 24'h7FFFFF);
    send(24'h800000, 24'h800000);

    // Backpressure: the sink stalls for 5 cycles while the source keeps offering a sample.
    do_clear();
    set_all(24'h400000, 24'h000000, 24'h000000, 24'h000000, 24'h000000);
    bus.out_ready = 1'b0;
    bus.in_data = 24'h0ABCDE;
    bus.in_valid = 1'b1;
    exp_q.push_back(24'h0ABCDE);
    tick();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 50 && !bus.out_valid; n++) tick();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 24'h123456;
      @(negedge clk);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_out_data", {8'h00, bus.out_data}, 32'h000ABCDE);
      check("bp_sos_idx", {30'd0, sos_idx}, 32'd3);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_idle", {31'd0, bus.in_ready}, 32'd1);
    check("bp_no_extra", {31'd0, bus.out_valid}, 32'd0);
    check("bp_queue", exp_q.size(), 32'd0);

    // Realistic coefficients, step response against the golden model.
    do_clear();
    tb0[0] = 24'h040000; tb1[0] = 24'h080000; tb2[0] = 24'h040000; ta1[0] = 24'hC00000; ta2[0] = 24'h133333;
    tb0[1] = 24'h100000; tb1[1] = 24'h000000; tb2[1] = 24'h080000; ta1[1] = 24'hD9999A; ta2[1] = 24'h0CCCCD;
    tb0[2] = 24'h200000; tb1[2] = 24'h100000; tb2[2] = 24'h000000; ta1[2] = 24'hE66666; ta2[2] = 24'h000000;
    tb0[3] = 24'h300000; tb1[3] = 24'h000000; tb2[3] = 24'h000000; ta1[3] = 24'h100000; ta2[3] = 24'h000000;
    for (int i = 0; i < 200; i++) send(24'h100000, model_step(24'h100000));

    // Abort a sample in CALC_Y with clear; nothing may come out for it.
    bus.in_data = 24'h100000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_sos_idx", {30'd0, sos_idx}, 32'd0);
    zero_model();
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 8; i++) begin
      imp_ref[i] = model_step((i == 0) ? 24'h200000 : 24'h000000);
      send((i == 0) ? 24'h200000 : 24'h000000, imp_ref[i]);
    end

    // Reset held for 2 cycles mid-sample, then the impulse response must match the post-clear one.
    send(24'h300000, model_step(24'h300000));
    bus.in_data = 24'h250000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick(); tick();
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mrst_sos_idx", {30'd0, sos_idx}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send((i == 0) ? 24'h200000 : 24'h000000, imp_ref[i]);

    tick(); tick();
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
